// File: rtl/mouse_sample_fifo.sv
// mouse_sample_fifo
// Buffers complete PS/2 mouse samples {status, X, Y, Z} between the mouse
// transceiver and the 8-bit processor bus. The head sample, FIFO flags and a
// control register sit in an 8-byte window at BASE_ADDR. An interrupt is
// raised when a sample is accepted and the post-push fill reaches the
// programmed threshold.
//
// Ports
//   CLK                    system clock, rising edge
//   RESET                  asynchronous reset, active low
//   SAMPLE_VALID           one-cycle pulse, new sample present
//   SAMPLE_STATUS[3:0]     {initialised, left, middle, right}
//   SAMPLE_X/Y/Z[7:0]      position/delta and scroll bytes
//   BUS_DATA[7:0]          shared bidirectional data bus
//   BUS_ADDR[7:0]          bus address
//   BUS_WE                 1 = processor write, 0 = read
//   MOUSE_INTERRUPT_RAISE  interrupt request
//   MOUSE_INTERRUPT_ACK    interrupt acknowledge
//
// Register window (offset from BASE_ADDR)
//   +0 R  {4'b0, head status}     +4 R  {overflow, full, empty, count[4:0]}
//   +1 R  head X                  +5 W  pop head entry
//   +2 R  head Y                  +6 RW {thresh[3:0], 3'b0, irq_en}
//   +3 R  head Z                  +7 W  clear overflow
module mouse_sample_fifo #(
    parameter logic [7:0] BASE_ADDR  = 8'hA0,
    parameter int         DEPTH      = 8,
    parameter int         DEF_THRESH = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SAMPLE_VALID,
    input  logic [3:0] SAMPLE_STATUS,
    input  logic [7:0] SAMPLE_X,
    input  logic [7:0] SAMPLE_Y,
    input  logic [7:0] SAMPLE_Z,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       MOUSE_INTERRUPT_RAISE,
    input  logic       MOUSE_INTERRUPT_ACK
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [4:0]    DEPTH5   = 5'(DEPTH);
    localparam logic [4:0]    DEF5     = 5'(DEF_THRESH);

    logic [27:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          irq_en_q, irq_en_d;
    logic [4:0]    thresh_q, thresh_d;
    logic          raise_q, raise_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          drive_q, drive_d;

    logic [7:0]  wdata;
    logic        in_win;
    logic [2:0]  offset;
    logic        wr_acc;
    logic        rd_acc;
    logic        empty;
    logic        full;
    logic [27:0] head;
    logic        do_pop;
    logic        do_push;
    logic        ctrl_wr;
    logic        ovf_clr;
    logic        irq_dis;
    logic [4:0]  wthr;
    logic        unused_wdata;

    assign wdata        = BUS_DATA;
    assign unused_wdata = ^wdata[3:1];

    assign in_win  = (BUS_ADDR[7:3] == BASE_ADDR[7:3]);
    assign offset  = BUS_ADDR[2:0];
    assign wr_acc  = in_win & BUS_WE;
    assign rd_acc  = in_win & ~BUS_WE;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign head    = empty ? 28'h0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push when a pop accompanies it.
    assign do_pop  = wr_acc & (offset == 3'd5) & ~empty;
    assign do_push = SAMPLE_VALID & (~full | do_pop);

    assign ctrl_wr = wr_acc & (offset == 3'd6);
    assign ovf_clr = wr_acc & (offset == 3'd7);
    assign irq_dis = ctrl_wr & ~wdata[0];

    always_comb begin
        wthr = {1'b0, wdata[7:4]};
        if (wthr == 5'd0) begin
            wthr = 5'd1;
        end else if (wthr > DEPTH5) begin
            wthr = DEPTH5;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        raise_d  = raise_q;
        rdata_d  = rdata_q;
        drive_d  = 1'b0;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Overflow is sticky: a drop in the same cycle as a clear wins.
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (SAMPLE_VALID && !do_push) begin
            ovf_d = 1'b1;
        end

        if (ctrl_wr) begin
            irq_en_d = wdata[0];
            thresh_d = wthr;
        end

        // Threshold is judged on the post-push fill level.
        if (do_push && irq_en_q && !irq_dis && (5'(count_d) >= thresh_q)) begin
            raise_d = 1'b1;
        end else if (MOUSE_INTERRUPT_ACK || irq_dis) begin
            raise_d = 1'b0;
        end

        // Read data reflects the state before this cycle's push/pop.
        if (rd_acc && (offset != 3'd5) && (offset != 3'd7)) begin
            drive_d = 1'b1;
            case (offset)
                3'd0:    rdata_d = {4'b0000, head[27:24]};
                3'd1:    rdata_d = head[23:16];
                3'd2:    rdata_d = head[15:8];
                3'd3:    rdata_d = head[7:0];
                3'd4:    rdata_d = {ovf_q, full, empty, 5'(count_q)};
                3'd6:    rdata_d = {thresh_q[3:0], 3'b000, irq_en_q};
                default: rdata_d = 8'h00;
            endcase
        end
    end

    // Storage carries no reset; the pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {SAMPLE_STATUS, SAMPLE_X, SAMPLE_Y, SAMPLE_Z};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b1;
            thresh_q <= DEF5;
            raise_q  <= 1'b0;
            rdata_q  <= 8'h00;
            drive_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            raise_q  <= raise_d;
            rdata_q  <= rdata_d;
            drive_q  <= drive_d;
        end
    end

    assign BUS_DATA              = drive_q ? rdata_q : 8'bz;
    assign MOUSE_INTERRUPT_RAISE = raise_q;

endmodule

// File: tb/tb_mouse_sample_fifo.sv
module tb_mouse_sample_fifo;

    localparam logic [7:0] BASE       = 8'hA0;
    localparam int         DEPTH      = 8;
    localparam int         DEF_THRESH = 1;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       SAMPLE_VALID = 1'b0;
    logic [3:0] SAMPLE_STATUS = '0;
    logic [7:0] SAMPLE_X = '0;
    logic [7:0] SAMPLE_Y = '0;
    logic [7:0] SAMPLE_Z = '0;
    wire  [7:0] BUS_DATA;
    logic [7:0] BUS_ADDR = '0;
    logic       BUS_WE = 1'b0;
    logic       MOUSE_INTERRUPT_RAISE;
    logic       MOUSE_INTERRUPT_ACK = 1'b0;

    logic [7:0] tb_bus = '0;
    logic       tb_drive = 1'b0;
    assign BUS_DATA = tb_drive ? tb_bus : 8'bz;

    mouse_sample_fifo #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .DEF_THRESH(DEF_THRESH)
    ) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .SAMPLE_VALID         (SAMPLE_VALID),
        .SAMPLE_STATUS        (SAMPLE_STATUS),
        .SAMPLE_X             (SAMPLE_X),
        .SAMPLE_Y             (SAMPLE_Y),
        .SAMPLE_Z             (SAMPLE_Z),
        .BUS_DATA             (BUS_DATA),
        .BUS_ADDR             (BUS_ADDR),
        .BUS_WE               (BUS_WE),
        .MOUSE_INTERRUPT_RAISE(MOUSE_INTERRUPT_RAISE),
        .MOUSE_INTERRUPT_ACK  (MOUSE_INTERRUPT_ACK)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [7:0]  wd;
        logic        sv;
        logic [27:0] smp;
        logic        ack;
        logic        exp_irq;
        logic        exp_drv;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // A released bus reads as Z (or as 0 in a two-state simulator).
    task automatic check_idle(input string name);
        checks++;
        if (!(BUS_DATA === 8'bz || BUS_DATA === 8'h00)) begin
            errors++;
            $display("FAIL %s: bus driven with %h expected released", name, BUS_DATA);
        end
    endtask

    function automatic vec_t v_idle(input logic irq);
        vec_t v;
        v.addr = 8'h00; v.we = 1'b0; v.wd = 8'h00; v.sv = 1'b0; v.smp = '0;
        v.ack = 1'b0; v.exp_irq = irq; v.exp_drv = 1'b0; v.exp_rd = 8'h00;
        return v;
    endfunction

    function automatic vec_t v_rd(input logic [2:0] off, input logic [7:0] exp, input logic irq);
        vec_t v = v_idle(irq);
        v.addr = {BASE[7:3], off}; v.exp_drv = 1'b1; v.exp_rd = exp;
        return v;
    endfunction

    function automatic vec_t v_wr(input logic [2:0] off, input logic [7:0] d, input logic irq);
        vec_t v = v_idle(irq);
        v.addr = {BASE[7:3], off}; v.we = 1'b1; v.wd = d;
        return v;
    endfunction

    function automatic vec_t v_push(input logic [27:0] s, input logic irq);
        vec_t v = v_idle(irq);
        v.sv = 1'b1; v.smp = s;
        return v;
    endfunction

    function automatic vec_t v_ack(input logic irq);
        vec_t v = v_idle(irq);
        v.ack = 1'b1;
        return v;
    endfunction

    function automatic logic [27:0] s_ovf(input int n);
        return {4'(n), 8'(32'h10 + n), 8'(32'h20 + n), 8'(32'h30 + n)};
    endfunction

    function automatic logic [27:0] s_thr(input int n);
        return {4'(n), 8'(32'h40 + n), 8'(32'h50 + n), 8'(32'h60 + n)};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        BUS_ADDR = v.addr; BUS_WE = v.we; tb_bus = v.wd; tb_drive = v.we;
        SAMPLE_VALID = v.sv;
        {SAMPLE_STATUS, SAMPLE_X, SAMPLE_Y, SAMPLE_Z} = v.smp;
        MOUSE_INTERRUPT_ACK = v.ack;
        @(posedge CLK);
        #1;
        tb_drive = 1'b0; BUS_WE = 1'b0; BUS_ADDR = 8'h00;
        SAMPLE_VALID = 1'b0; MOUSE_INTERRUPT_ACK = 1'b0;
        #1;
        check_bit($sformatf("vec%0d_irq", idx), MOUSE_INTERRUPT_RAISE, v.exp_irq);
        if (v.exp_drv) check8($sformatf("vec%0d_rd", idx), BUS_DATA, v.exp_rd);
        else           check_idle($sformatf("vec%0d_idle", idx));
    endtask

    // Behavioural reference: a queue of samples plus flag/config state.
    logic [27:0] mq[$];
    bit          m_ovf;
    bit          m_en;
    bit          m_raise;
    int          m_thresh;

    function automatic logic [7:0] m_read(input logic [2:0] off);
        logic [27:0] h;
        h = (mq.size() > 0) ? mq[0] : 28'h0;
        case (off)
            3'd0: return {4'b0000, h[27:24]};
            3'd1: return h[23:16];
            3'd2: return h[15:8];
            3'd3: return h[7:0];
            3'd4: return {m_ovf, mq.size() == DEPTH, mq.size() == 0, 5'(mq.size())};
            3'd6: return {4'(m_thresh), 3'b000, m_en};
            default: return 8'h00;
        endcase
    endfunction

    logic [2:0]  offs [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [2:0]  r_off;
    logic [7:0]  r_addr, r_wd, r_exp;
    logic        r_we, r_sv, r_ack, r_read, r_pop, r_ctrl, r_clr, prev_read;
    logic [27:0] r_smp, dummy;
    int          r_sel, r_t;
    bit          m_dopop, m_dopush;

    initial begin
        // Directed table
        tbl.push_back(v_rd(3'd4, 8'h20, 1'b0));
        tbl.push_back(v_rd(3'd0, 8'h00, 1'b0));
        tbl.push_back(v_push({4'h8, 8'h05, 8'hFB, 8'h01}, 1'b1));
        tbl.push_back(v_rd(3'd0, 8'h08, 1'b1));
        tbl.push_back(v_rd(3'd1, 8'h05, 1'b1));
        tbl.push_back(v_rd(3'd2, 8'hFB, 1'b1));
        tbl.push_back(v_rd(3'd3, 8'h01, 1'b1));
        tbl.push_back(v_ack(1'b0));
        tbl.push_back(v_wr(3'd5, 8'h00, 1'b0));
        tbl.push_back(v_rd(3'd4, 8'h20, 1'b0));
        tbl.push_back(v_idle(1'b0));
        for (int n = 1; n <= 9; n++) tbl.push_back(v_push(s_ovf(n), 1'b1));
        tbl.push_back(v_rd(3'd4, 8'hC8, 1'b1));
        tbl.push_back(v_rd(3'd0, 8'h01, 1'b1));
        for (int n = 1; n <= 8; n++) begin
            tbl.push_back(v_rd(3'd1, 8'(32'h10 + n), 1'b1));
            tbl.push_back(v_idle(1'b1));
            tbl.push_back(v_wr(3'd5, 8'h00, 1'b1));
        end
        tbl.push_back(v_rd(3'd4, 8'hA0, 1'b1));
        tbl.push_back(v_idle(1'b1));
        tbl.push_back(v_wr(3'd7, 8'h00, 1'b1));
        tbl.push_back(v_rd(3'd4, 8'h20, 1'b1));
        tbl.push_back(v_ack(1'b0));
        tbl.push_back(v_wr(3'd6, 8'h31, 1'b0));
        tbl.push_back(v_rd(3'd6, 8'h31, 1'b0));
        tbl.push_back(v_push(s_thr(1), 1'b0));
        tbl.push_back(v_push(s_thr(2), 1'b0));
        tbl.push_back(v_push(s_thr(3), 1'b1));
        begin
            vec_t v = v_push(s_thr(4), 1'b1);
            v.ack = 1'b1;
            tbl.push_back(v);
        end
        tbl.push_back(v_ack(1'b0));
        for (int n = 5; n <= 8; n++) tbl.push_back(v_push(s_thr(n), 1'b1));
        begin
            vec_t v = v_wr(3'd5, 8'h00, 1'b1);
            v.sv = 1'b1; v.smp = s_thr(9);
            tbl.push_back(v);
        end
        tbl.push_back(v_rd(3'd4, 8'h48, 1'b1));
        tbl.push_back(v_idle(1'b1));
        for (int n = 0; n < 7; n++) tbl.push_back(v_wr(3'd5, 8'h00, 1'b1));
        tbl.push_back(v_rd(3'd1, 8'h49, 1'b1));
        tbl.push_back(v_rd(3'd0, 8'h09, 1'b1));
        tbl.push_back(v_rd(3'd4, 8'h01, 1'b1));
        tbl.push_back(v_idle(1'b1));
        begin
            vec_t v = v_idle(1'b1);
            v.addr = 8'h9E;
            tbl.push_back(v);
            v.addr = 8'hA8;
            tbl.push_back(v);
        end
        tbl.push_back(v_wr(3'd1, 8'h5A, 1'b1));
        tbl.push_back(v_rd(3'd1, 8'h49, 1'b1));
        tbl.push_back(v_idle(1'b1));
        tbl.push_back(v_wr(3'd6, 8'h00, 1'b0));
        tbl.push_back(v_rd(3'd6, 8'h10, 1'b0));
        tbl.push_back(v_idle(1'b0));
        tbl.push_back(v_wr(3'd6, 8'hF1, 1'b0));
        tbl.push_back(v_rd(3'd6, 8'h81, 1'b0));
        tbl.push_back(v_idle(1'b0));

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check_idle("reset_bus");
        check_bit("reset_irq", MOUSE_INTERRUPT_RAISE, 1'b0);
        @(posedge CLK);
        #2 RESET = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Reset during a read of +1: drive must drop at once
        BUS_ADDR = {BASE[7:3], 3'd1}; BUS_WE = 1'b0;
        @(posedge CLK);
        #1;
        check8("rst_pre_read", BUS_DATA, 8'h49);
        BUS_ADDR = 8'h00;
        RESET = 1'b0;
        #1;
        check_idle("rst_async_release");
        check_bit("rst_irq", MOUSE_INTERRUPT_RAISE, 1'b0);
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b1;
        run_vec(v_rd(3'd4, 8'h20, 1'b0), 1000);
        run_vec(v_rd(3'd0, 8'h00, 1'b0), 1001);
        run_vec(v_rd(3'd6, {4'(DEF_THRESH), 3'b000, 1'b1}, 1'b0), 1002);

        // Randomised traffic against the queue model
        mq.delete();
        m_ovf = 0; m_en = 1; m_raise = 0; m_thresh = DEF_THRESH;
        prev_read = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r_addr = 8'h00; r_we = 1'b0; r_wd = 8'h00;
            r_read = 1'b0; r_pop = 1'b0; r_ctrl = 1'b0; r_clr = 1'b0;
            r_off = 3'd0;
            r_sel = int'($urandom_range(0, 19));
            if (r_sel < 8) begin
                r_off = offs[$urandom_range(0, 5)];
                r_addr = {BASE[7:3], r_off}; r_read = 1'b1;
            end else if (r_sel < 12 && !prev_read) begin
                r_addr = {BASE[7:3], 3'd5}; r_we = 1'b1; r_pop = 1'b1;
                r_wd = 8'($urandom);
            end else if (r_sel == 12 && !prev_read) begin
                r_addr = {BASE[7:3], 3'd6}; r_we = 1'b1; r_ctrl = 1'b1;
                r_wd = 8'($urandom);
            end else if (r_sel == 13 && !prev_read) begin
                r_addr = {BASE[7:3], 3'd7}; r_we = 1'b1; r_clr = 1'b1;
            end else if (r_sel == 14) begin
                r_addr = 8'($urandom_range(0, 159));
            end
            r_sv  = !r_ctrl && !r_clr &&
                    ($urandom_range(0, (i < 1500) ? 2 : 7) == 0);
            r_smp = 28'($urandom);
            r_ack = ($urandom_range(0, 5) == 0);

            r_exp = m_read(r_off);
            m_dopop  = r_pop && (mq.size() > 0);
            m_dopush = r_sv && ((mq.size() < DEPTH) || m_dopop);
            if (r_sv && !m_dopush) m_ovf = 1;
            if (m_dopop) dummy = mq.pop_front();
            if (m_dopush) mq.push_back(r_smp);
            if (r_clr) m_ovf = 0;
            if (m_dopush && m_en && (mq.size() >= m_thresh)) m_raise = 1;
            else if (r_ack) m_raise = 0;
            if (r_ctrl) begin
                m_en = r_wd[0];
                r_t = int'(r_wd[7:4]);
                if (r_t == 0) r_t = 1;
                if (r_t > DEPTH) r_t = DEPTH;
                m_thresh = r_t;
                if (!m_en) m_raise = 0;
            end

            BUS_ADDR = r_addr; BUS_WE = r_we; tb_bus = r_wd; tb_drive = r_we;
            SAMPLE_VALID = r_sv;
            {SAMPLE_STATUS, SAMPLE_X, SAMPLE_Y, SAMPLE_Z} = r_smp;
            MOUSE_INTERRUPT_ACK = r_ack;
            @(posedge CLK);
            #1;
            tb_drive = 1'b0; BUS_WE = 1'b0; BUS_ADDR = 8'h00;
            SAMPLE_VALID = 1'b0; MOUSE_INTERRUPT_ACK = 1'b0;
            #1;
            check_bit($sformatf("rnd%0d_irq", i), MOUSE_INTERRUPT_RAISE, m_raise);
            if (r_read) check8($sformatf("rnd%0d_rd_off%0d", i, r_off), BUS_DATA, r_exp);
            else        check_idle($sformatf("rnd%0d_idle", i));
            prev_read = r_read;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mouse_sample_fifo.md
Name: mouse_sample_fifo

Overview:
- Parametrised successor of the single-sample PS/2 mouse bus peripheral. It sits between MouseTransceiver and the 8-bit processor bus.
- Buffers up to DEPTH complete mouse samples (status, X, Y, Z) in a FIFO, so packets are not lost while the processor services other work.
- Exposes the head sample and FIFO flags in a relocatable register window.
- Raises a threshold-based interrupt with a raise/acknowledge handshake.

Parameters:
- BASE_ADDR, 8'hA0: first bus address of the 8-byte register window; must be 8-aligned.
- DEPTH, 8: FIFO depth in samples; power of 2, range 2..16.
- DEF_THRESH, 1: reset value of the interrupt threshold; range 1..DEPTH.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- SAMPLE_VALID  in  1  one-cycle pulse from the transceiver: a new sample is present.
- SAMPLE_STATUS  in  4  {initialised, left, middle, right}.
- SAMPLE_X  in  8  X position/delta byte.
- SAMPLE_Y  in  8  Y position/delta byte.
- SAMPLE_Z  in  8  scroll byte.
- BUS_DATA  inout  8  shared processor data bus.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  1 = processor write, 0 = read.
- MOUSE_INTERRUPT_RAISE  out  1  interrupt request to the processor.
- MOUSE_INTERRUPT_ACK  in  1  interrupt acknowledge from the processor.

Behaviour:
- Reset (RESET=0, asynchronous):
  - FIFO empty, count=0, overflow=0.
  - irq_en=1, thresh=DEF_THRESH.
  - MOUSE_INTERRUPT_RAISE=0, BUS_DATA released (Z), output register=0.
- FIFO storage: 28-bit entries {status, X, Y, Z}; rd/wr pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is 0..DEPTH.
- Push: on a cycle with SAMPLE_VALID=1, write the sample at wr_ptr.
- Push when full (and no pop in the same cycle): sample dropped, FIFO contents unchanged, overflow set. Overflow is sticky.
- Pop: a bus write to BASE+5 (data ignored) removes the head entry. A pop when empty is ignored.
- Simultaneous push and pop:
  - Not empty: both take effect, count unchanged.
  - Full: both take effect, no overflow.
  - Empty: push only.
- Register map (offsets from BASE_ADDR):
  - +0 R: {4'b0, head status}.
  - +1 R: head X.
  - +2 R: head Y.
  - +3 R: head Z.
  - +4 R: {overflow, full, empty, count[4:0]}.
  - +5 W: pop.
  - +6 R/W: CTRL {thresh[7:4], 3'b0, irq_en[0]}. A written thresh of 0 is stored as 1; values above DEPTH are stored as DEPTH.
  - +7 W: clears overflow.
- Head reads (+0..+3) return 8'h00 when the FIFO is empty.
- Read timing: data is registered. When BUS_WE=0 and BUS_ADDR is in {+0..+4, +6}, BUS_DATA is driven with the register value on the following cycle.
- Bus release: BUS_DATA is Z the cycle after any write or any out-of-window address.
- Read content: reflects FIFO state before any push or pop occurring in the same cycle.
- Unmapped offsets: writes to read-only offsets are ignored.
- Interrupt:
  - MOUSE_INTERRUPT_RAISE is set 1 cycle after a successful push when irq_en=1 and post-push count >= thresh.
  - Otherwise it is cleared 1 cycle after MOUSE_INTERRUPT_ACK=1. Set wins over ACK in the same cycle.
  - Writing irq_en=0 also clears it.
  - Dropped pushes never raise the interrupt.
- Reset mid-transfer: a pending bus drive is released immediately and the FIFO is discarded.

Test Plan:
- Reset, then read BASE+4 -> 8'h20 (empty) one cycle later. Read BASE+0 -> 8'h00. MOUSE_INTERRUPT_RAISE=0.
- Push {4'h8, 8'h05, 8'hFB, 8'h01} -> interrupt rises 1 cycle later. Reads give +0=8'h08, +1=8'h05, +2=8'hFB, +3=8'h01. ACK -> raise low next cycle. Write +5 -> +4 reads 8'h20.
- Push 9 distinct samples with DEPTH=8 -> +4 reads 8'hC8. Head is sample 1. Pop 8 times, reading each -> samples 1..8 in order. Write +7 -> +4 reads 8'h20.
- Write CTRL 8'h31 (thresh=3); push 2 samples -> no interrupt. Push a 3rd -> raise set. Assert ACK in the same cycle as a 4th push -> raise stays 1.
- FIFO full; SAMPLE_VALID and a pop write in the same cycle -> count stays 8, overflow stays 0, new sample is at the tail.
- Address outside the window, or BUS_WE=1 -> BUS_DATA stays Z. Assert RESET low during a read of +1 -> BUS_DATA Z immediately, +4 reads 8'h20 after release.
